// File: rtl/conv_bin_bcd_iter_pkg.sv
// Shared types and the add-3 digit correction used by the binary-to-BCD converter.
// Contents: FSM state enum, add-3 constant, ajuste_bcd() helper.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_estado_t;

    localparam logic [3:0] BCD_AJUSTE = 4'd3;

    // A digit >= 5 would become >= 10 after the next doubling,
    // so it is pre-corrected by +3 to carry cleanly into the next digit.
    function automatic logic [3:0] ajuste_bcd(input logic [3:0] d);
        return (d >= 4'd5) ? d + BCD_AJUSTE : d;
    endfunction

endpackage

// File: rtl/conv_bin_bcd_iter_if.sv
// Handshake/data bundle of the binary-to-BCD converter.
// master: start, modo_hex, dato_in -> ; slave: digitos, ovf, busy, done ->.
interface conv_bin_bcd_iter_if #(
    parameter int W_IN  = 14,
    parameter int N_DIG = 4
);
    logic                 start;
    logic                 modo_hex;
    logic [W_IN-1:0]      dato_in;
    logic [4*N_DIG-1:0]   digitos;
    logic                 ovf;
    logic                 busy;
    logic                 done;

    modport master (
        output start, modo_hex, dato_in,
        input  digitos, ovf, busy, done
    );

    modport slave (
        input  start, modo_hex, dato_in,
        output digitos, ovf, busy, done
    );
endinterface

// File: rtl/conv_bin_bcd_iter_digito.sv
// One BCD digit of the add-3 correction stage (combinational).
// Ports: i_dig current nibble, o_dig corrected nibble.
module bcd_ajuste_digito
    import conv_pkg::*;
(
    input  logic [3:0] i_dig,
    output logic [3:0] o_dig
);

    assign o_dig = ajuste_bcd(i_dig);

endmodule

// File: rtl/conv_bin_bcd_iter.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, plus hex passthrough.
// Ports: clk, rst (async, active-high), bus (slave: start/modo_hex/dato_in in; digitos/ovf/busy/done out).
module conv_bin_bcd_iter
    import conv_pkg::*;
#(
    parameter int W_IN  = 14,
    parameter int N_DIG = 4
) (
    input  logic                clk,
    input  logic                rst,
    conv_bin_bcd_iter_if.slave  bus
);

    localparam int W_ACC = 4 * N_DIG;
    localparam int W_CNT = $clog2(W_IN + 1);
    localparam int W_EXT = (W_IN > W_ACC) ? W_IN : W_ACC;

    conv_estado_t       r_estado;
    conv_estado_t       w_sig;

    logic [W_IN-1:0]    r_bin;
    logic [W_ACC-1:0]   r_acc;
    logic [W_CNT-1:0]   r_cnt;
    logic               r_ovf_int;
    logic [W_ACC-1:0]   r_dig;
    logic               r_ovf;

    logic [W_ACC-1:0]   w_adj;
    logic [W_ACC-1:0]   w_sh_acc;
    logic               w_sh_ovf;
    logic [W_EXT-1:0]   w_ext;
    logic               w_hex_ovf;
    logic               w_acepta;
    logic               w_ultimo;

    for (genvar g = 0; g < N_DIG; g++) begin : g_dig
        bcd_ajuste_digito u_dig (
            .i_dig (r_acc[4*g +: 4]),
            .o_dig (w_adj[4*g +: 4])
        );
    end

    // The bit leaving the top digit is a carry into a digit we do not keep.
    assign w_sh_acc = {w_adj[W_ACC-2:0], r_bin[W_IN-1]};
    assign w_sh_ovf = w_adj[W_ACC-1];

    assign w_ext     = W_EXT'(bus.dato_in);
    assign w_hex_ovf = |(w_ext >> W_ACC);

    assign w_acepta = bus.start && (r_estado != SHIFT);
    assign w_ultimo = (r_cnt == W_CNT'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado <= IDLE;
        end else begin
            r_estado <= w_sig;
        end
    end

    always_comb begin
        w_sig = r_estado;
        unique case (r_estado)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_sig = bus.modo_hex ? DONE : SHIFT;
                end else begin
                    w_sig = IDLE;
                end
            end
            SHIFT: begin
                if (w_ultimo) begin
                    w_sig = DONE;
                end
            end
            default: w_sig = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin     <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_int <= 1'b0;
            r_dig     <= '0;
            r_ovf     <= 1'b0;
        end else if (w_acepta) begin
            r_bin     <= bus.dato_in;
            r_acc     <= '0;
            r_ovf_int <= 1'b0;
            if (bus.modo_hex) begin
                r_cnt <= '0;
                r_dig <= w_ext[W_ACC-1:0];
                r_ovf <= w_hex_ovf;
            end else begin
                r_cnt <= W_CNT'(W_IN);
            end
        end else if (r_estado == SHIFT) begin
            r_acc     <= w_sh_acc;
            r_bin     <= r_bin << 1;
            r_cnt     <= r_cnt - W_CNT'(1);
            r_ovf_int <= r_ovf_int | w_sh_ovf;
            if (w_ultimo) begin
                r_dig <= w_sh_acc;
                r_ovf <= r_ovf_int | w_sh_ovf;
            end
        end
    end

    assign bus.digitos = r_dig;
    assign bus.ovf     = r_ovf;
    assign bus.busy    = (r_estado == SHIFT);
    assign bus.done    = (r_estado == DONE);

endmodule

// File: tb/tb_conv_bin_bcd_iter.sv
// Self-checking bench for conv_bin_bcd_iter (N_DIG=4 and N_DIG=5 side by side).
// Table-driven vectors plus hand-written hold/abort/back-to-back sequences.
module tb_conv_bin_bcd_iter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_bin_bcd_iter_if #(.W_IN(14), .N_DIG(4)) b4 ();
    conv_bin_bcd_iter_if #(.W_IN(14), .N_DIG(5)) b5 ();

    assign b5.start    = b4.start;
    assign b5.modo_hex = b4.modo_hex;
    assign b5.dato_in  = b4.dato_in;

    conv_bin_bcd_iter #(.W_IN(14), .N_DIG(4)) dut4 (
        .clk (clk), .rst (rst), .bus (b4.slave)
    );
    conv_bin_bcd_iter #(.W_IN(14), .N_DIG(5)) dut5 (
        .clk (clk), .rst (rst), .bus (b5.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        hex;
        logic [13:0] d;
        logic [15:0] e4;
        logic        o4;
        logic [19:0] e5;
        logic        o5;
    } vec_t;

    vec_t tab[10];

    // Issue a one-cycle start, then count busy cycles and latency to done.
    task automatic conv(input logic hex, input logic [13:0] d,
                        output int nbusy, output int lat, output logic got);
        @(negedge clk);
        b4.start    = 1'b1;
        b4.modo_hex = hex;
        b4.dato_in  = d;
        @(posedge clk);
        #1;
        b4.start = 1'b0;
        nbusy = 0;
        lat   = 0;
        got   = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (b4.busy) nbusy++;
            if (b4.done) got = 1'b1;
        end
    endtask

    int nbusy, lat, ndone;
    logic got;

    initial begin
        tab[0] = '{1'b0, 14'd9999,  16'h9999, 1'b0, 20'h09999, 1'b0};
        tab[1] = '{1'b0, 14'd16383, 16'h6383, 1'b1, 20'h16383, 1'b0};
        tab[2] = '{1'b0, 14'd0,     16'h0000, 1'b0, 20'h00000, 1'b0};
        tab[3] = '{1'b0, 14'd1234,  16'h1234, 1'b0, 20'h01234, 1'b0};
        tab[4] = '{1'b0, 14'd10000, 16'h0000, 1'b1, 20'h10000, 1'b0};
        tab[5] = '{1'b0, 14'd42,    16'h0042, 1'b0, 20'h00042, 1'b0};
        tab[6] = '{1'b0, 14'd1,     16'h0001, 1'b0, 20'h00001, 1'b0};
        tab[7] = '{1'b0, 14'd8191,  16'h8191, 1'b0, 20'h08191, 1'b0};
        tab[8] = '{1'b1, 14'h2ABC,  16'h2ABC, 1'b0, 20'h02ABC, 1'b0};
        tab[9] = '{1'b1, 14'h3FFF,  16'h3FFF, 1'b0, 20'h03FFF, 1'b0};

        b4.start    = 1'b0;
        b4.modo_hex = 1'b0;
        b4.dato_in  = '0;
        repeat (2) @(negedge clk);
        chk("rst_digitos", 32'(b4.digitos), 32'h0);
        chk("rst_ovf",     32'(b4.ovf),     32'h0);
        chk("rst_busy",    32'(b4.busy),    32'h0);
        chk("rst_done",    32'(b4.done),    32'h0);
        chk("rst_dig5",    32'(b5.digitos), 32'h0);
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            conv(tab[v].hex, tab[v].d, nbusy, lat, got);
            chk($sformatf("v%0d_got", v),  32'(got), 32'h1);
            chk($sformatf("v%0d_lat", v),  32'(lat),
                tab[v].hex ? 32'd1 : 32'd15);
            chk($sformatf("v%0d_busy", v), 32'(nbusy),
                tab[v].hex ? 32'd0 : 32'd14);
            chk($sformatf("v%0d_dig4", v), 32'(b4.digitos), 32'(tab[v].e4));
            chk($sformatf("v%0d_ovf4", v), 32'(b4.ovf),     32'(tab[v].o4));
            chk($sformatf("v%0d_dig5", v), 32'(b5.digitos), 32'(tab[v].e5));
            chk($sformatf("v%0d_ovf5", v), 32'(b5.ovf),     32'(tab[v].o5));
            @(negedge clk);
            chk($sformatf("v%0d_pulse", v), 32'(b4.done), 32'h0);
            chk($sformatf("v%0d_hold", v), 32'(b4.digitos), 32'(tab[v].e4));
        end

        // Start pulses while busy are ignored; old result holds until done.
        conv(1'b0, 14'd1234, nbusy, lat, got);
        chk("pre_hold", 32'(b4.digitos), 32'h1234);
        @(negedge clk);
        b4.start   = 1'b1;
        b4.dato_in = 14'd42;
        @(posedge clk);
        #1;
        b4.start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (b4.done) begin
                ndone++;
                chk("ign_lat", 32'(i), 32'd15);
                chk("ign_dig", 32'(b4.digitos), 32'h0042);
                chk("ign_ovf", 32'(b4.ovf), 32'h0);
            end else if (ndone == 0) begin
                chk($sformatf("ign_hold%0d", i), 32'(b4.digitos), 32'h1234);
            end
            b4.start   = (i == 3 || i == 8);
            b4.dato_in = b4.start ? 14'd77 : 14'd42;
        end
        chk("ign_ndone", 32'(ndone), 32'd1);

        // Asynchronous abort in the middle of a conversion.
        @(negedge clk);
        b4.start   = 1'b1;
        b4.dato_in = 14'd1234;
        @(posedge clk);
        #1;
        b4.start = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(b4.busy),    32'h0);
        chk("abort_done", 32'(b4.done),    32'h0);
        chk("abort_dig",  32'(b4.digitos), 32'h0);
        chk("abort_ovf",  32'(b4.ovf),     32'h0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b4.done) ndone++;
        end
        chk("abort_nodone", 32'(ndone), 32'd0);
        conv(1'b0, 14'd1234, nbusy, lat, got);
        chk("abort_re_got", 32'(got), 32'h1);
        chk("abort_re_dig", 32'(b4.digitos), 32'h1234);

        // Back-to-back: start held high through DONE.
        @(negedge clk);
        b4.start   = 1'b1;
        b4.dato_in = 14'd0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (b4.done) got = 1'b1;
        end
        chk("b2b_got1", 32'(got), 32'h1);
        chk("b2b_dig1", 32'(b4.digitos), 32'h0);
        chk("b2b_ovf1", 32'(b4.ovf), 32'h0);
        b4.dato_in = 14'd5;
        @(posedge clk);
        #1;
        b4.start = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (b4.done) got = 1'b1;
        end
        chk("b2b_got2", 32'(got), 32'h1);
        chk("b2b_gap",  32'(lat), 32'd15);
        chk("b2b_dig2", 32'(b4.digitos), 32'h0005);
        chk("b2b_ovf2", 32'(b4.ovf), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
